// File: rtl/fir_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer_if
//   Control bundle between the FIR MAC sequencer and its datapath.
//   master : the sequencer (drives RAM/ROM addresses and MAC enables)
//   slave  : the datapath / sample source (drives sample_valid and ovr_clr)
//
//   sample_valid  new input sample present          (slave -> master)
//   sample_ready  sequencer can accept a sample     (master -> slave)
//   dl_wr_en      delay-line RAM write strobe
//   dl_wr_addr    delay-line write address
//   dl_rd_addr    delay-line read address
//   coef_addr     coefficient ROM address
//   mac_clr       accumulator = product (first tap)
//   mac_en        accumulator += product
//   result_load   one-cycle strobe to the output register
//   busy          filter run in progress
//   overrun       sticky: sample offered while not ready
//   ovr_clr       clears overrun                    (slave -> master)
// ---------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              sample_valid;
  logic              sample_ready;
  logic              dl_wr_en;
  logic [ADDR_W-1:0] dl_wr_addr;
  logic [ADDR_W-1:0] dl_rd_addr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              result_load;
  logic              busy;
  logic              overrun;
  logic              ovr_clr;

  modport master (
    input  sample_valid, ovr_clr,
    output sample_ready, dl_wr_en, dl_wr_addr, dl_rd_addr, coef_addr,
           mac_clr, mac_en, result_load, busy, overrun
  );

  modport slave (
    output sample_valid, ovr_clr,
    input  sample_ready, dl_wr_en, dl_wr_addr, dl_rd_addr, coef_addr,
           mac_clr, mac_en, result_load, busy, overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
//   Control FSM for a time-multiplexed FIR filter. Each accepted sample is
//   written into a circular delay line at the write pointer, then TAPS
//   cycles walk coefficient index k and delay-line address (wp - k), issuing
//   mac_clr on the first tap and mac_en on every tap. PIPE drain cycles let
//   the MAC pipeline empty before result_load captures the accumulator.
//
//   Parameters: TAPS (power of two), ADDR_W = log2(TAPS), PIPE (0..7)
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      fir_mac_sequencer_if.master (handshake, addresses, MAC ctrl)
// ---------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int TAPS   = 16,
  parameter int ADDR_W = 4,
  parameter int PIPE   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fir_mac_sequencer_if.master    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  // Never reached when PIPE = 0 because DRAIN is skipped entirely.
  localparam logic [2:0]        DRAIN_LAST = (PIPE > 0) ? 3'(PIPE - 1) : 3'd0;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] wp_q,      wp_d;
  logic [ADDR_W-1:0] k_q,       k_d;
  logic [2:0]        drain_q,   drain_d;
  logic              overrun_q, overrun_d;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    k_d       = k_q;
    drain_d   = drain_q;
    overrun_d = overrun_q;

    // Clear first, then set, so a coincident violation wins.
    if (bus.ovr_clr) overrun_d = 1'b0;
    if (bus.sample_valid && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.sample_valid) begin
          state_d = S_MAC;
          k_d     = '0;
        end
      end
      S_MAC: begin
        // k holds at the last tap so the addresses stay put through DRAIN.
        if (k_q == K_LAST) begin
          state_d = (PIPE > 0) ? S_DRAIN : S_OUT;
          drain_d = '0;
        end else begin
          k_d = k_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_OUT;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        wp_d    = wp_q + ADDR_ONE;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs are decoded from state and counters. The single exception is the
  // RAM write strobe, which must fire in the same cycle the sample is offered.
  assign bus.sample_ready = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.dl_wr_en     = (state_q == S_IDLE) && bus.sample_valid;
  assign bus.dl_wr_addr   = wp_q;
  assign bus.coef_addr    = k_q;
  // Newest sample first: tap k reads the sample written k runs ago.
  assign bus.dl_rd_addr   = wp_q - k_q;
  assign bus.mac_en       = (state_q == S_MAC);
  assign bus.mac_clr      = (state_q == S_MAC) && (k_q == '0);
  assign bus.result_load  = (state_q == S_OUT);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
  localparam int TAPS    = 4;
  localparam int ADDR_W  = 2;
  localparam int PIPE    = 2;
  localparam int RUN_LEN = TAPS + PIPE + 1;  // accept-to-result_load cycles
  localparam int PS      = PIPE - 1;         // pipeline stage feeding the accumulator

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  fir_mac_sequencer_if #(.ADDR_W(ADDR_W)) bus0 ();

  fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .PIPE(PIPE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .PIPE(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.master)
  );

  // ---------------- datapath model driven by the sequencer ----------------
  logic [15:0]  sample_data;
  int unsigned  ram [TAPS] = '{default: 0};
  int unsigned  coef [TAPS] = '{3, 5, 7, 9};
  logic [31:0]  prod;
  logic         pe_en  [PIPE] = '{default: 1'b0};
  logic         pe_clr [PIPE] = '{default: 1'b0};
  logic [31:0]  pe_p   [PIPE] = '{default: 32'd0};
  logic [31:0]  acc = 32'd0;
  logic [31:0]  out_reg = 32'd0;

  always_comb prod = ram[bus.dl_rd_addr] * coef[bus.coef_addr];

  always @(posedge clk) begin
    if (bus.dl_wr_en) ram[bus.dl_wr_addr] <= 32'(sample_data);
    pe_en[0]  <= bus.mac_en;
    pe_clr[0] <= bus.mac_clr;
    pe_p[0]   <= prod;
    for (int i = 1; i < PIPE; i++) begin
      pe_en[i]  <= pe_en[i-1];
      pe_clr[i] <= pe_clr[i-1];
      pe_p[i]   <= pe_p[i-1];
    end
    if (pe_clr[PS])     acc <= pe_p[PS];
    else if (pe_en[PS]) acc <= acc + pe_p[PS];
    if (bus.result_load) out_reg <= acc;
  end

  // ---------------- result_load timestamp monitor ----------------
  int cyc = 0;
  int rl_cycles[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.result_load) rl_cycles.push_back(cyc);

  // ---------------- reference model: plain convolution ----------------
  int unsigned hist[$];
  int          wp_m = 0;

  function automatic logic [31:0] expected_y();
    logic [31:0] sum = 32'd0;
    for (int k = 0; k < TAPS; k++)
      if (hist.size() > k) sum += coef[k] * hist[hist.size() - 1 - k];
    return sum;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready",   bus.sample_ready, 1);
    check("rst_busy",    bus.busy,         0);
    check("rst_overrun", bus.overrun,      0);
    check("rst_wr_en",   bus.dl_wr_en,     0);
    check("rst_mac_clr", bus.mac_clr,      0);
    check("rst_mac_en",  bus.mac_en,       0);
    check("rst_rl",      bus.result_load,  0);
    check("rst_wr_addr", bus.dl_wr_addr,   0);
    check("rst_rd_addr", bus.dl_rd_addr,   0);
    check("rst_coef",    bus.coef_addr,    0);
  endtask

  // Called in an idle cycle; returns in the first idle cycle after the run.
  task automatic run_sample(input logic [15:0] data, input bit check_val);
    sample_data      = data;
    bus.sample_valid = 1'b1;
    #1;
    check("acc_ready",   bus.sample_ready, 1);
    check("acc_wr_en",   bus.dl_wr_en,     1);
    check("acc_wr_addr", bus.dl_wr_addr,   wp_m);
    hist.push_back(32'(data));
    for (int c = 1; c <= RUN_LEN; c++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      #1;
      check("run_busy",    bus.busy,         1);
      check("run_ready",   bus.sample_ready, 0);
      check("run_wr_en",   bus.dl_wr_en,     0);
      check("run_mac_en",  bus.mac_en,       c <= TAPS);
      check("run_mac_clr", bus.mac_clr,      c == 1);
      check("run_rl",      bus.result_load,  c == RUN_LEN);
      if (c <= TAPS) begin
        check("run_coef",    bus.coef_addr,  c - 1);
        check("run_rd_addr", bus.dl_rd_addr, (wp_m + TAPS - (c - 1)) % TAPS);
      end
    end
    @(negedge clk);
    #1;
    check("end_ready", bus.sample_ready, 1);
    check("end_busy",  bus.busy,         0);
    if (check_val) check("out_reg", out_reg, expected_y());
    wp_m = (wp_m + 1) % TAPS;
  endtask

  int imp_exp [5] = '{3000, 5000, 7000, 9000, 0};
  int rl_saved;

  initial begin
    reset_n           = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.ovr_clr       = 1'b0;
    bus0.sample_valid = 1'b0;
    bus0.ovr_clr      = 1'b0;
    sample_data       = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);
    #1;

    // Five back-to-back samples: write addresses 0,1,2,3,0 and 8-cycle spacing
    for (int i = 0; i < 5; i++) run_sample(16'($urandom_range(0, 1000)), 1'b1);
    check("rl_count", rl_cycles.size(), 5);
    for (int i = 1; i < 5; i++) check("rl_spacing", rl_cycles[i] - rl_cycles[i-1], RUN_LEN + 1);

    // PIPE = 0 build: result_load one cycle after the last mac_en
    @(negedge clk);
    bus0.sample_valid = 1'b1;
    #1;
    check("p0_wr_en", bus0.dl_wr_en, 1);
    for (int c = 1; c <= TAPS + 2; c++) begin
      @(negedge clk);
      bus0.sample_valid = 1'b0;
      #1;
      check("p0_mac_en", bus0.mac_en,       c <= TAPS);
      check("p0_rl",     bus0.result_load,  c == TAPS + 1);
      check("p0_ready",  bus0.sample_ready, c == TAPS + 2);
    end

    // More randomized runs against the convolution model
    for (int i = 0; i < 6; i++) run_sample(16'($urandom_range(0, 60000)), 1'b1);

    // Impulse response: flush with zeros, then 1000 followed by zeros
    for (int i = 0; i < TAPS - 1; i++) run_sample(16'd0, 1'b1);
    run_sample(16'd1000, 1'b1);
    check("impulse", out_reg, imp_exp[0]);
    for (int i = 1; i < 5; i++) begin
      run_sample(16'd0, 1'b1);
      check("impulse", out_reg, imp_exp[i]);
    end

    // Overrun: valid during MAC, clear, then clear coincident with violation
    sample_data      = 16'($urandom_range(1, 1000));
    bus.sample_valid = 1'b1;
    #1;
    check("ovr_accept", bus.dl_wr_en, 1);
    hist.push_back(32'(sample_data));
    @(negedge clk);
    sample_data = 16'hBEEF;                  // must never reach the RAM
    #1;
    check("ovr_no_write", bus.dl_wr_en, 0);
    check("ovr_not_yet",  bus.overrun,  0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    #1;
    check("ovr_set", bus.overrun, 1);
    @(negedge clk);
    bus.ovr_clr = 1'b1;
    #1;
    check("ovr_held", bus.overrun, 1);
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    #1;
    check("ovr_cleared", bus.overrun, 0);
    @(negedge clk);                         // cycle 5: DRAIN
    bus.sample_valid = 1'b1;
    bus.ovr_clr      = 1'b1;
    #1;
    check("ovr_drain_no_write", bus.dl_wr_en, 0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.ovr_clr      = 1'b0;
    #1;
    check("ovr_set_wins", bus.overrun, 1);
    @(negedge clk);
    #1;
    check("ovr_run_rl", bus.result_load, 1);
    @(negedge clk);
    #1;
    check("ovr_run_ready", bus.sample_ready, 1);
    check("ovr_run_out",   out_reg,          expected_y());
    wp_m = (wp_m + 1) % TAPS;

    // Reset at cycle 3 of a run: overrun is still set going in
    rl_saved         = rl_cycles.size();
    sample_data      = 16'($urandom_range(0, 1000));
    bus.sample_valid = 1'b1;
    #1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mid_run_mac", bus.mac_en, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (RUN_LEN) @(negedge clk);
    #1;
    check("no_rl_after_reset", rl_cycles.size(), rl_saved);
    wp_m = 0;
    run_sample(16'($urandom_range(0, 1000)), 1'b0);
    check("rl_after_reset", rl_cycles.size(), rl_saved + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
